// File: rtl/reload_counter_gen.sv
// Self-reloading timer/tick counter: up/down, one-shot or periodic, prescaled, registered tc pulse.
// Optional sticky terminal-count interrupt enabled by defining RELOAD_COUNTER_IRQ_EN.
module reload_counter_gen #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   load_val_i,
    input  logic               dir_i,
    input  logic               oneshot_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               irq_clr_i,
    output logic [WIDTH-1:0]   count_o,
    output logic               tc_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               irq_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               dir_q, dir_d;
    logic               oneshot_q, oneshot_d;
    logic               tc_q, tc_d;
    logic               irq_q, irq_d;

    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   terminal;
    logic               tick;

    assign start_val = dir_q ? '0 : reload_q;
    assign terminal  = dir_q ? reload_q : '0;
    assign tick      = (state_q == StRun) && (presc_q == prescale_i);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        oneshot_d = oneshot_q;
        tc_d      = 1'b0;

        // Control priority: load > stop > start > tick.
        if (load_i) begin
            reload_d  = load_val_i;
            dir_d     = dir_i;
            oneshot_d = oneshot_i;
            count_d   = dir_i ? '0 : load_val_i;
            presc_d   = '0;
        end else if (stop_i) begin
            if (state_q == StRun) begin
                state_d = StIdle;
            end
        end else if (start_i) begin
            dir_d     = dir_i;
            oneshot_d = oneshot_i;
            count_d   = dir_i ? '0 : reload_q;
            presc_d   = '0;
            state_d   = StRun;
        end else if (state_q == StRun) begin
            if (tick) begin
                presc_d = '0;
                if (count_q == terminal) begin
                    tc_d = 1'b1;
                    if (oneshot_q) begin
                        state_d = StDone;
                    end else begin
                        count_d = start_val;
                    end
                end else if (dir_q) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

`ifdef RELOAD_COUNTER_IRQ_EN
    // Set wins over a coincident clear.
    assign irq_d = tc_d | (irq_q & ~irq_clr_i);
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_d          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            oneshot_q <= oneshot_d;
            tc_q      <= tc_d;
            irq_q     <= irq_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign busy_o  = (state_q == StRun);
    assign done_o  = (state_q == StDone);
    assign irq_o   = irq_q;

endmodule
